// File: rtl/regfile_mp_pkg.sv
// Shared core types for the integer register file and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_mp_pkg;

    // Architectural defaults for the rv32i integer file.
    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REG_AW   = $clog2(NREGS);

    typedef logic [XLEN-1:0]   data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic              enable_t;

    // INIT walks the array writing zeros; READY is normal operation.
    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage : regfile_mp_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue beats write on the same register.
// Latency: set/clear land at the clock edge; busy outputs are registered bits read combinationally.
// Backpressure: none; inputs are ignored while i_live is low (clear sequence running).
//
// Ports:
//   clk, rst         clock, async active-high reset (clears every busy bit)
//   i_live           register file is out of INIT; gates updates and outputs
//   i_issue_en/_rd   issuing instruction and its destination register
//   i_wen/i_wr_addr  writeback enables and addresses (one per write port)
//   i_rs_addr        read-port addresses; o_rs_busy is the busy bit of each
module regfile_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_live,
    input  logic                      i_issue_en,
    input  logic [AW-1:0]             i_issue_rd,
    input  logic [NUM_WR-1:0]         i_wen,
    input  logic [NUM_WR-1:0][AW-1:0] i_wr_addr,
    input  logic [NUM_RD-1:0][AW-1:0] i_rs_addr,
    output logic [NUM_RD-1:0]         o_rs_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Clears are applied first so a same-cycle issue to the same register
    // leaves the bit set: the new producer owns the register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_live) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wen[w]) begin
                    w_busy_nxt[i_wr_addr[w]] = 1'b0;
                end
            end
            if (i_issue_en) begin
                w_busy_nxt[i_issue_rd] = 1'b1;
            end
        end
        // x0 has no producer, so its bit is pinned low.
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Registered bits only; same-cycle issues/writes are not forwarded.
    always_comb begin
        o_rs_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            o_rs_busy[r] = i_live & r_busy[i_rs_addr[r]];
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and post-reset zeroing sequencer.
// Latency: reads combinational (0 cycles, optional same-cycle write bypass); writes land at the edge.
// Backpressure: none; init_done_o low for NUM_REGS-1 cycles after reset, during which writes/issues are dropped.
//
// Ports:
//   clk, rst                    clock, async active-high reset (restarts the clear sequence)
//   rs_addr_i / rs_data_o       NUM_RD read ports, data is 0 for x0 and while in INIT
//   rs_busy_o                   registered busy bit of each read address
//   wen_i, wr_addr_i, wr_data_i NUM_WR write ports, highest index wins on collision
//   issue_en_i, issue_rd_i      marks the destination of an issuing instruction busy
//   init_done_o                 clear sequence finished, ports are live
module regfile_mp #(
    parameter  int NUM_REGS = 32,
    parameter  int DATA_W   = 32,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RD-1:0][AW-1:0]     rs_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0] rs_data_o,
    output logic [NUM_RD-1:0]             rs_busy_o,
    input  logic [NUM_WR-1:0]             wen_i,
    input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
    input  logic                          issue_en_i,
    input  logic [AW-1:0]                 issue_rd_i,
    output logic                          init_done_o
);

    import regfile_mp_pkg::*;

    rf_state_e            r_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_init_done;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];

    logic                          w_live;
    logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

    assign w_live = (r_state == RF_READY);

    // Clear sequencer. Counter starts at 1 because x0 is never stored
    // meaningfully (reads of x0 are forced to zero), and it stops at
    // NUM_REGS-1 so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RF_INIT;
            r_cnt       <= AW'(1);
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                RF_INIT: begin
                    if (r_cnt == AW'(NUM_REGS - 1)) begin
                        r_state     <= RF_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                RF_READY: begin
                    r_state     <= RF_READY;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= RF_INIT;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign init_done_o = r_init_done;

    // Storage has no reset; the sequencer zeroes it one entry per cycle.
    // Later loop iterations overwrite earlier ones, giving the highest
    // write port priority on an address collision.
    always_ff @(posedge clk) begin
        if (r_state == RF_INIT) begin
            r_regs[r_cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen_i[w] && (wr_addr_i[w] != '0)) begin
                    r_regs[wr_addr_i[w]] <= wr_data_i[w];
                end
            end
        end
    end

    // Read muxes. Bypass scans ports in ascending order so the highest
    // matching port's data is the one left standing.
    always_comb begin
        w_rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (w_live && (rs_addr_i[r] != '0)) begin
                w_rd_data[r] = r_regs[rs_addr_i[r]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wen_i[w] && (wr_addr_i[w] == rs_addr_i[r])) begin
                            w_rd_data[r] = wr_data_i[w];
                        end
                    end
                end
            end
        end
    end

    assign rs_data_o = w_rd_data;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_live     (w_live),
        .i_issue_en (issue_en_i),
        .i_issue_rd (issue_rd_i),
        .i_wen      (wen_i),
        .i_wr_addr  (wr_addr_i),
        .i_rs_addr  (rs_addr_i),
        .o_rs_busy  (rs_busy_o)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic                 clk;
    logic                 rst;
    logic [1:0][4:0]      rs_addr;
    logic [1:0]           wen;
    logic [1:0][4:0]      wr_addr;
    logic [1:0][31:0]     wr_data;
    logic                 issue_en;
    logic [4:0]           issue_rd;

    logic [1:0][31:0]     a_data, b_data;
    logic [1:0]           a_busy, b_busy;
    logic                 a_done, b_done;

    regfile_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(a_data), .rs_busy_o(a_busy),
        .wen_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_rd_i(issue_rd), .init_done_o(a_done)
    );

    regfile_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(b_data), .rs_busy_o(b_busy),
        .wen_i(wen), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_rd_i(issue_rd), .init_done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observable selectors for the scoreboard queue.
    localparam int S_A0 = 0, S_A1 = 1, S_B0 = 2, S_B1 = 3, S_ABSY0 = 4, S_ABSY1 = 5;
    localparam int S_ADONE = 6, S_BBSY0 = 7, S_BDONE = 8;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    bit          m_live;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_obs(input int sel);
        case (sel)
            S_A0:    return a_data[0];
            S_A1:    return a_data[1];
            S_B0:    return b_data[0];
            S_B1:    return b_data[1];
            S_ABSY0: return {31'b0, a_busy[0]};
            S_ABSY1: return {31'b0, a_busy[1]};
            S_ADONE: return {31'b0, a_done};
            S_BBSY0: return {31'b0, b_busy[0]};
            S_BDONE: return {31'b0, b_done};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic exp_push(input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Compare everything queued for this cycle at the falling edge, then
    // advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, get_obs(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen      = '0;
        wr_addr  = '0;
        wr_data  = '0;
        issue_en = 1'b0;
        issue_rd = '0;
        rs_addr  = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_live = 1'b0;
    endtask

    // Apply the current inputs to the reference model (what the edge commits).
    task automatic model_commit();
        if (m_live) begin
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
                if (wen[w]) m_busy[wr_addr[w]] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    // Expected outputs for the current inputs, from the model state before the edge.
    task automatic push_model();
        logic [31:0] e;
        logic [4:0]  a;
        for (int r = 0; r < 2; r++) begin
            a = rs_addr[r];
            e = (a == 0) ? 32'h0 : m_regs[a];
            exp_push(S_B0 + r, e, "rnd_nobyp_data");
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && wr_addr[w] == a && a != 0) e = wr_data[w];
            end
            exp_push(S_A0 + r, e, "rnd_byp_data");
            exp_push(S_ABSY0 + r, {31'b0, m_busy[a]}, "rnd_busy");
        end
    endtask

    // Run the clear sequence with junk writes/issues that must be ignored.
    task automatic run_init(input string tag);
        for (int k = 0; k < 31; k++) begin
            rs_addr  = {5'd31, 5'd5};
            wen      = 2'b11;
            wr_addr  = {5'd31, 5'd5};
            wr_data  = {32'hFFFF_FFFF, 32'hA5A5_A5A5};
            issue_en = 1'b1;
            issue_rd = 5'd5;
            exp_push(S_ADONE, 32'd0, {tag, "_done_low"});
            exp_push(S_BDONE, 32'd0, {tag, "_done_low_b"});
            exp_push(S_A0, 32'd0, {tag, "_rd0_zero"});
            exp_push(S_A1, 32'd0, {tag, "_rd1_zero"});
            exp_push(S_ABSY0, 32'd0, {tag, "_busy_zero"});
            tick();
        end
        idle_inputs();
        rs_addr = {5'd31, 5'd5};
        exp_push(S_ADONE, 32'd1, {tag, "_done_high"});
        exp_push(S_BDONE, 32'd1, {tag, "_done_high_b"});
        exp_push(S_A0, 32'd0, {tag, "_x5_cleared"});
        exp_push(S_A1, 32'd0, {tag, "_x31_cleared"});
        exp_push(S_ABSY0, 32'd0, {tag, "_x5_not_busy"});
        tick();
        m_live = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        rs_addr = {5'd3, 5'd5};
        exp_push(S_ADONE, 32'd0, "rst_done");
        exp_push(S_A0, 32'd0, "rst_data0");
        exp_push(S_A1, 32'd0, "rst_data1");
        exp_push(S_ABSY0, 32'd0, "rst_busy0");
        exp_push(S_ABSY1, 32'd0, "rst_busy1");
        tick();
        rst = 1'b0;
        run_init("init");

        // Single write, bypass versus no bypass.
        wen = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF; rs_addr[0] = 5'd5;
        exp_push(S_A0, 32'hDEAD_BEEF, "x5_bypass");
        exp_push(S_B0, 32'h0, "x5_nobypass_old");
        model_commit(); tick();
        idle_inputs(); rs_addr[0] = 5'd5;
        exp_push(S_A0, 32'hDEAD_BEEF, "x5_next_byp");
        exp_push(S_B0, 32'hDEAD_BEEF, "x5_next_nobyp");
        tick();

        // Write-port priority on collision.
        wen = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222_2222, 32'h1111_1111};
        rs_addr[1] = 5'd7;
        exp_push(S_A1, 32'h2222_2222, "x7_prio_bypass");
        exp_push(S_B1, 32'h0, "x7_nobypass_old");
        model_commit(); tick();
        idle_inputs(); rs_addr[1] = 5'd7;
        exp_push(S_A1, 32'h2222_2222, "x7_prio_next");
        exp_push(S_B1, 32'h2222_2222, "x7_prio_next_b");
        tick();

        // x0 is hardwired.
        wen = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234_5678;
        issue_en = 1'b1; issue_rd = 5'd0; rs_addr = '0;
        exp_push(S_A0, 32'h0, "x0_bypass_zero");
        exp_push(S_B0, 32'h0, "x0_nobyp_zero");
        model_commit(); tick();
        idle_inputs();
        exp_push(S_A0, 32'h0, "x0_next_zero");
        exp_push(S_ABSY0, 32'h0, "x0_busy_zero");
        tick();

        // Scoreboard set / same-cycle set-clear / clear.
        issue_en = 1'b1; issue_rd = 5'd9; rs_addr[1] = 5'd9;
        exp_push(S_ABSY1, 32'd0, "x9_busy_not_yet");
        model_commit(); tick();
        wen = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h0000_0099;
        exp_push(S_ABSY1, 32'd1, "x9_busy_set");
        model_commit(); tick();
        issue_en = 1'b0; wr_data[0] = 32'h0000_00AA;
        exp_push(S_ABSY1, 32'd1, "x9_issue_beats_write");
        model_commit(); tick();
        idle_inputs(); rs_addr[1] = 5'd9;
        exp_push(S_ABSY1, 32'd0, "x9_busy_cleared");
        exp_push(S_A1, 32'h0000_00AA, "x9_data");
        tick();

        // Randomised traffic on a narrow address range to force collisions.
        for (int c = 0; c < 300; c++) begin
            for (int w = 0; w < 2; w++) begin
                wen[w]     = 1'($urandom_range(1, 0));
                wr_addr[w] = 5'($urandom_range(7, 0));
                wr_data[w] = $urandom;
            end
            for (int r = 0; r < 2; r++) rs_addr[r] = 5'($urandom_range(7, 0));
            issue_en = 1'($urandom_range(1, 0));
            issue_rd = 5'($urandom_range(7, 0));
            push_model();
            model_commit();
            tick();
        end

        // Reset while READY with x3 holding data and marked busy.
        idle_inputs();
        wen = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h3333_3333;
        model_commit(); tick();
        idle_inputs(); issue_en = 1'b1; issue_rd = 5'd3;
        model_commit(); tick();
        idle_inputs(); rs_addr[0] = 5'd3;
        for (int k = 0; k < 10; k++) begin
            exp_push(S_ABSY0, 32'd1, "pre_rst_busy_x3");
            exp_push(S_A0, 32'h3333_3333, "pre_rst_x3");
            tick();
        end
        rst = 1'b1;
        #1;
        exp_push(S_ADONE, 32'd0, "mid_rst_done");
        exp_push(S_ABSY0, 32'd0, "mid_rst_busy");
        exp_push(S_BBSY0, 32'd0, "mid_rst_busy_b");
        exp_push(S_A0, 32'd0, "mid_rst_data");
        tick();
        rst = 1'b0;
        model_reset();
        run_init("reinit");
        rs_addr[0] = 5'd3;
        exp_push(S_A0, 32'h0, "x3_after_reinit");
        exp_push(S_B0, 32'h0, "x3_after_reinit_b");
        exp_push(S_ABSY0, 32'd0, "x3_busy_after_reinit");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the rv32i core: NUM_RD combinational read ports, NUM_WR write ports with fixed priority, and optional write-to-read bypass. It adds a per-register busy scoreboard for hazard detection and a post-reset clear sequencer that zeroes the array without a reset on every flop. It sits between decode (reads, issue) and writeback (writes).

## Interface
- NUM_REGS, 32, architectural register count; power of two, >= 2; AW = $clog2(NUM_REGS)
- DATA_W, 32, register width
- NUM_RD, 2, read port count, >= 1
- NUM_WR, 2, write port count, >= 1; higher index has priority
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rs_addr_i  in  NUM_RD x AW  read addresses
- rs_data_o  out  NUM_RD x DATA_W  read data
- rs_busy_o  out  NUM_RD  scoreboard busy bit of each read address
- wen_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR x AW  write addresses
- wr_data_i  in  NUM_WR x DATA_W  write data
- issue_en_i  in  1  an instruction with a destination register issues this cycle
- issue_rd_i  in  AW  destination of the issuing instruction
- init_done_o  out  1  clear sequence complete; ports are live

## Operation
- Two-state FSM, INIT and READY. rst forces INIT, clear counter = 1, all busy bits = 0.
- INIT: each cycle writes 0 to regs[counter] and increments the counter. When counter == NUM_REGS-1, that register is written and the FSM moves to READY. wen_i and issue_en_i are ignored; rs_data_o = 0 and rs_busy_o = 0 on every port.
- READY: normal operation. Stays in READY until rst.
- Register 0: reads return 0, writes are dropped, busy bit is never set and always reads 0.
- Writes: every port with wen_i=1 and a nonzero address updates the array at the clock edge. If several ports hit the same address, the highest-index port wins.
- Reads: combinational. With BYPASS=1, if any enabled write port targets rs_addr_i (nonzero), rs_data_o is that port's wr_data_i (highest index wins). Otherwise rs_data_o is the array value.
- Scoreboard: issue_en_i with nonzero issue_rd_i sets busy[issue_rd_i]. An enabled write clears busy[wr_addr]. If the issue and a write hit the same register in the same cycle, the busy bit ends up 1 (the new producer wins).
- rs_busy_o reflects the registered busy bits and is not bypassed by same-cycle writes or issues.
- Upstream guarantees at most one outstanding producer per register; the block does not count producers.

## Timing
- Reset values: init_done_o = 0, rs_busy_o = 0, rs_data_o = 0, FSM = INIT, counter = 1.
- init_done_o is registered. It goes to 1 in the cycle after the NUM_REGS-1-th rising edge following rst deassertion (31 edges for NUM_REGS=32).
- Read latency: 0 cycles. A write is visible in the array from the edge it is written on, and in the same cycle when BYPASS=1.
- Busy set and clear take effect at the edge. rs_busy_o changes in the cycle after issue or write.
- rst asserted mid-INIT or mid-READY: outputs return to reset values immediately. Array contents are undefined until the new INIT completes.
- Counter width is AW; it never wraps, because the FSM leaves INIT at NUM_REGS-1.

## Structure
- The shared core package holds data_t, reg_addr_t, enable_t (already shared) and the new rf_state_e {RF_INIT, RF_READY}.
- One sub-module, regfile_scoreboard: busy bit vector, issue/write set-clear priority, and register-0 masking. The array, FSM, and bypass muxes stay in regfile_mp.

## Test plan
- Reset then idle, NUM_REGS=32: init_done_o=0 for 31 edges, then 1; all reads return 0 both during and after INIT.
- READY: write x5=0xDEADBEEF on port 0; the same cycle read of x5 returns 0xDEADBEEF with BYPASS=1, and the prior value with BYPASS=0. The next cycle returns 0xDEADBEEF in both cases.
- Ports 0 and 1 both write x7 (0x11111111 and 0x22222222) in the same cycle: the bypass read and the next-cycle read both return 0x22222222.
- Write x0=0x12345678 and issue rd=x0: x0 reads 0 and rs_busy_o stays 0.
- Issue rd=x9 -> busy[x9]=1 the next cycle. A write to x9 together with a new issue rd=x9 in the same cycle -> busy stays 1. A write to x9 alone -> busy 0 the next cycle.
- Assert rst after 10 READY cycles with busy x3 set: init_done_o and rs_busy_o drop immediately; after 31 edges, x3 reads 0 and busy is 0.
